aq_f_spsram_zinit: RTL and testbench
====================================

AQ_F_SPSRAM_ZINIT -- requirements
Module: aq_f_spsram_zinit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-003 SHALL have parameter OUT_REG, default 0, 0 = no output register, 1 = one extra output register stage.
REQ-004 SHALL have one clock and one reset: CLK input 1, clock; RST input 1, reset, synchronous, active-high.
REQ-005 SHALL have CEN input 1, chip enable, active-low.
REQ-006 SHALL have GWEN input 1, global write enable, active-high: 1 = write, 0 = read.
REQ-007 SHALL have WEN input DATA_WIDTH, per-bit write enable, active-high.
REQ-008 SHALL have A input ADDR_WIDTH, word address.
REQ-009 SHALL have D input DATA_WIDTH, write data.
REQ-010 SHALL have CLR input 1, one-cycle request to re-zero the whole array.
REQ-011 SHALL have Q output DATA_WIDTH, read data.
REQ-012 SHALL have QVLD output 1, one-cycle pulse marking new read data on Q.
REQ-013 SHALL have INIT_BUSY output 1, high while zero-initialisation runs; accesses are dropped.

Function
REQ-014 SHALL hold a DEPTH x DATA_WIDTH behavioural array, with all state updated on rising CLK only.
REQ-015 SHALL implement FSM states INIT and READY; INIT_BUSY = (state == INIT).
REQ-016 INIT SHALL write all-zero to mem[cnt] each cycle and increment the ADDR_WIDTH-bit counter cnt.
REQ-017 INIT SHALL go to READY in the cycle that writes cnt == DEPTH-1; cnt wraps to 0.
REQ-018 READY with CLR=1 SHALL go to INIT with cnt=0, and the same-cycle access SHALL be dropped.
REQ-019 INIT with CLR=1 SHALL restart cnt at 0 and stay in INIT.
REQ-020 An access is accepted only when state == READY, CEN=0 and CLR=0; otherwise the array, Q and QVLD SHALL NOT change because of it.
REQ-021 An accepted write SHALL set mem[A][i] = D[i] for every i with WEN[i]=1, SHALL leave the other bits unchanged, and SHALL NOT change Q or raise QVLD.
REQ-022 A write with WEN all-zero SHALL leave the array unchanged.
REQ-023 An accepted read SHALL present mem[A] on Q, with QVLD=1, after 1 + OUT_REG cycles.
REQ-024 Q SHALL hold the last read data until the next read data arrives; QVLD SHALL be 0 in all other cycles.
REQ-025 Back-to-back reads, one per cycle, SHALL be fully pipelined with no bubbles in either OUT_REG setting.
REQ-026 A read issued the cycle after a write to the same address SHALL return the new data; a write does not complete until the following edge.
REQ-027 A read in flight when CLR is accepted SHALL still complete with its pre-clear data.
REQ-028 No access is ever accepted during INIT, so read/init collisions SHALL NOT occur.

Reset
REQ-029 RST=1 at an edge SHALL set state=INIT, cnt=0, Q=0, QVLD=0, and clear any pipelined read valid.
REQ-030 INIT_BUSY SHALL read 1 in the cycle after any RST edge.
REQ-031 After RST falls, INIT_BUSY SHALL stay 1 for exactly DEPTH cycles, then go to 0.
REQ-032 RST asserted mid-INIT or mid-read SHALL restart initialisation from cnt=0 and discard the pending read.
REQ-033 Array contents SHALL NOT be cleared by RST directly; only the INIT sweep zeroes them.

Verification
REQ-034 Release RST, defaults: INIT_BUSY=1 for 1024 cycles, then 0; a read of every address returns 0x0000.
REQ-035 Write A=0x005, D=0xA5A5, WEN=0xFFFF; write A=0x005, D=0xFFFF, WEN=0x00F0; read A=0x005 -> Q=0xA5F5 with QVLD one cycle after the read (two cycles with OUT_REG=1).
REQ-036 Reads of A=1,2,3 on consecutive cycles after writes 0x1111, 0x2222, 0x3333 -> QVLD high 3 consecutive cycles, Q=0x1111, 0x2222, 0x3333; Q holds 0x3333 afterwards.
REQ-037 Pulse CLR after data writes; accesses issued while INIT_BUSY=1 are ignored; once INIT_BUSY=0, all reads return 0.
REQ-038 Assert RST at cnt=500 of INIT: after release, INIT_BUSY=1 for a full 1024 cycles; a read issued with CEN=0 during INIT gives no QVLD.
REQ-039 With CEN=1 and random GWEN/A/D/WEN for 100 cycles, the array is unchanged and QVLD stays 0.

Source files
------------

// File: rtl/aq_f_spsram_zinit.sv
// Single-port behavioural SRAM with a hardware zero-initialisation sweep after reset or CLR,
// per-bit write enables and a 1 + OUT_REG cycle read pipeline.
module aq_f_spsram_zinit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  CLR,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QVLD,
    output logic                  INIT_BUSY
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    acc, wr_acc, rd_acc;
    logic [STAGES:1]         vld_pipe;
    logic [STAGES:1][DATA_WIDTH-1:0] dat_pipe;

    // Only READY cycles with no clear pending may touch the array or the read pipe.
    assign acc       = (state == READY) && !CEN && !CLR && !RST;
    assign wr_acc    = acc && GWEN;
    assign rd_acc    = acc && !GWEN;
    assign INIT_BUSY = (state == INIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INIT: begin
                if (CLR) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == '1) state_nxt = READY;
                end
            end
            READY: begin
                if (CLR) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Array has no reset; only the sweep zeroes it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == INIT)
                mem[cnt] <= '0;
            else if (wr_acc)
                mem[A] <= (mem[A] & ~WEN) | (D & WEN);
        end
    end

    // Data stages only load on a valid read so Q holds the last read value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) dat_pipe[1] <= mem[A];
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign Q    = dat_pipe[STAGES];
    assign QVLD = vld_pipe[STAGES];

endmodule

// File: tb/tb_aq_f_spsram_zinit.sv
// Directed bench: drives one OUT_REG=0 and one OUT_REG=1 instance with identical stimulus
// and checks Q/QVLD/INIT_BUSY of both every cycle against hand-computed read results.
module tb_aq_f_spsram_zinit;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, cen = 1'b1, gwen = 1'b0, clr = 1'b0;
    logic [DW-1:0] wen = '0, d = '0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] q0, q1;
    logic          qv0, qv1, b0, b1;

    int checks = 0;
    int failures = 0;

    // Bench-side expectation state: pending latency-2 result and held Q values.
    logic          pv = 1'b0;
    logic [DW-1:0] pd = '0, exq0 = '0, exq1 = '0;

    aq_f_spsram_zinit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) u0 (
        .CLK(clk), .RST(rst), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d), .CLR(clr),
        .Q(q0), .QVLD(qv0), .INIT_BUSY(b0));

    aq_f_spsram_zinit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) u1 (
        .CLK(clk), .RST(rst), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d), .CLR(clr),
        .Q(q1), .QVLD(qv1), .INIT_BUSY(b1));

    typedef struct {
        logic          r, c, g;
        logic [DW-1:0] w;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
        logic          cl, erd;
        logic [DW-1:0] ed;
        logic          eb;
        string         nm;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then compare both instances.
    // erd/ed: this cycle's access is an accepted read returning ed.
    task automatic step(input logic r, c, g, input logic [DW-1:0] w, input logic [AW-1:0] ad,
                        input logic [DW-1:0] dd, input logic cl, input logic erd,
                        input logic [DW-1:0] ed, input logic eb, input string nm);
        logic v1, v2;
        logic [DW-1:0] d2;
        rst = r; cen = c; gwen = g; wen = w; a = ad; d = dd; clr = cl;
        @(posedge clk);
        #1;
        if (r) begin
            v1 = 1'b0; v2 = 1'b0; pv = 1'b0; exq0 = '0; exq1 = '0;
        end else begin
            v1 = erd; v2 = pv; d2 = pd;
            pv = erd; pd = ed;
            if (v1) exq0 = ed;
            if (v2) exq1 = d2;
        end
        chk({nm, ":qvld0"}, 32'(qv0), 32'(v1));
        chk({nm, ":q0"},    32'(q0),  32'(exq0));
        chk({nm, ":qvld1"}, 32'(qv1), 32'(v2));
        chk({nm, ":q1"},    32'(q1),  32'(exq1));
        chk({nm, ":busy0"}, 32'(b0),  32'(eb));
        chk({nm, ":busy1"}, 32'(b1),  32'(eb));
    endtask

    task automatic idle(input string nm);
        step(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, nm);
    endtask

    task automatic rd(input logic [AW-1:0] ad, input logic [DW-1:0] ed, input string nm);
        step(1'b0, 1'b0, 1'b0, '0, ad, '0, 1'b0, 1'b1, ed, 1'b0, nm);
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dd, input string nm);
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, ad, dd, 1'b0, 1'b0, '0, 1'b0, nm);
    endtask

    task automatic rst_cyc(input string nm);
        step(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1, nm);
    endtask

    // INIT sweep: n edges; busy drops only after edge DEPTH. Traffic hammers addr 10,
    // which must all be ignored.
    task automatic init_run(input int n, input string nm);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, i[0], 16'hFFFF, 10'd10, 16'hFFFF, 1'b0, 1'b0, '0,
                 (i < DEPTH - 1), nm);
    endtask

    function automatic void add(input logic c, g, input logic [DW-1:0] w, input logic [AW-1:0] ad,
                                input logic [DW-1:0] dd, input logic erd, input logic [DW-1:0] ed,
                                input string nm);
        vec_t v;
        v.r = 1'b0; v.c = c; v.g = g; v.w = w; v.ad = ad; v.dd = dd;
        v.cl = 1'b0; v.erd = erd; v.ed = ed; v.eb = 1'b0; v.nm = nm;
        tv.push_back(v);
    endfunction

    initial begin
        // READY-phase directed vectors, starting from an all-zero array.
        add(0, 1, 16'hFFFF, 10'h005, 16'hA5A5, 0, '0,        "wr5_full");
        add(0, 1, 16'h00F0, 10'h005, 16'hFFFF, 0, '0,        "wr5_mask");
        add(0, 0, 16'h0000, 10'h005, 16'h0000, 1, 16'hA5F5, "rd5");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "hold_a");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "hold_b");
        add(0, 1, 16'h0000, 10'h005, 16'h0000, 0, '0,        "wr5_wen0");
        add(0, 0, 16'h0000, 10'h005, 16'h0000, 1, 16'hA5F5, "rd5_wen0");
        add(0, 1, 16'hFFFF, 10'h001, 16'h1111, 0, '0,        "wr1");
        add(0, 1, 16'hFFFF, 10'h002, 16'h2222, 0, '0,        "wr2");
        add(0, 1, 16'hFFFF, 10'h003, 16'h3333, 0, '0,        "wr3");
        add(0, 0, 16'h0000, 10'h001, 16'h0000, 1, 16'h1111, "bb_rd1");
        add(0, 0, 16'h0000, 10'h002, 16'h0000, 1, 16'h2222, "bb_rd2");
        add(0, 0, 16'h0000, 10'h003, 16'h0000, 1, 16'h3333, "bb_rd3");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "bb_hold_a");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "bb_hold_b");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "bb_hold_c");
        add(0, 1, 16'hFFFF, 10'h007, 16'hBEEF, 0, '0,        "raw_wr7");
        add(0, 0, 16'h0000, 10'h007, 16'h0000, 1, 16'hBEEF, "raw_rd7");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "raw_idle");
        add(0, 1, 16'hFFFF, 10'h008, 16'h1234, 0, '0,        "wr_keeps_q");
        add(1, 0, 16'h0000, 10'h000, 16'h0000, 0, '0,        "wr_keeps_q2");

        // Reset and first sweep.
        rst_cyc("reset_a");
        rst_cyc("reset_b");
        init_run(DEPTH, "init0");
        for (int i = 0; i < DEPTH; i++) rd(i[AW-1:0], 16'h0000, "zero_all");
        idle("zero_drain_a");
        idle("zero_drain_b");

        foreach (tv[i])
            step(tv[i].r, tv[i].c, tv[i].g, tv[i].w, tv[i].ad, tv[i].dd, tv[i].cl,
                 tv[i].erd, tv[i].ed, tv[i].eb, tv[i].nm);

        // Deselected random traffic must not disturb the array or raise QVLD.
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 10'($urandom),
                 16'($urandom), 1'b0, 1'b0, '0, 1'b0, "cen_hi");
        rd(10'h001, 16'h1111, "post_cen_rd1");
        rd(10'h002, 16'h2222, "post_cen_rd2");
        rd(10'h003, 16'h3333, "post_cen_rd3");
        rd(10'h005, 16'hA5F5, "post_cen_rd5");
        rd(10'h007, 16'hBEEF, "post_cen_rd7");
        rd(10'h008, 16'h1234, "post_cen_rd8");
        idle("post_cen_a");
        idle("post_cen_b");

        // CLR with a read in flight; the CLR-cycle read is dropped; CLR again mid-sweep.
        wr(10'h00A, 16'h4321, "pre_clr_wr10");
        rd(10'h007, 16'hBEEF, "inflight_rd7");
        step(1'b0, 1'b0, 1'b0, '0, 10'h001, '0, 1'b1, 1'b0, '0, 1'b1, "clr_ready");
        init_run(300, "clr_part");
        step(1'b0, 1'b0, 1'b0, '0, 10'h001, '0, 1'b1, 1'b0, '0, 1'b1, "clr_in_init");
        init_run(DEPTH, "clr_sweep");
        rd(10'h001, 16'h0000, "clr_rd1");
        rd(10'h005, 16'h0000, "clr_rd5");
        rd(10'h007, 16'h0000, "clr_rd7");
        rd(10'h00A, 16'h0000, "clr_rd10");
        idle("clr_drain_a");
        idle("clr_drain_b");

        // RST mid-read, then RST mid-sweep at cnt=500.
        wr(10'h014, 16'h5555, "rst_wr20");
        rd(10'h014, 16'h5555, "rst_rd20");
        rst_cyc("rst_midread");
        init_run(500, "rst_part");
        rst_cyc("rst_midinit");
        init_run(DEPTH, "rst_sweep");
        rd(10'h014, 16'h0000, "rst_rd20");
        rd(10'h00A, 16'h0000, "rst_rd10");
        idle("end_a");
        idle("end_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
